digit_serial_adder: RTL

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

---
 rtl/adder_pkg.sv | 11 +
 rtl/adder_slice.sv | 22 ++
 rtl/digit_serial_adder.sv | 109 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the digit-serial adder.
package adder_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adder_slice.sv
// DIGIT-wide combinational ripple-carry adder, time-shared across digits.
module adder_slice #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out
);
    logic c;

    always_comb begin
        c   = c_in;
        s_d = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i] = a_d[i] ^ b_d[i] ^ c;
            c      = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
        end
        c_out = c;
    end
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide slice processes the operands
// LSB digit first over NDIG cycles, then holds the result until consumed.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, bx_r, s_r;
    logic             carry, cout_r, ovf_r;
    logic [CW-1:0]    cnt;
    logic             last;
    int               idx;
    logic [DIGIT-1:0] a_d, b_d, s_d;
    logic             c_d;

    assign last = (cnt == CW'(NDIG - 1));

    always_comb begin
        idx = int'(cnt) * DIGIT;
        a_d = a_r[idx +: DIGIT];
        b_d = bx_r[idx +: DIGIT];
    end

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a_d  (a_d),
        .b_d  (b_d),
        .c_in (carry),
        .s_d  (s_d),
        .c_out(c_d)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_n = RUN;
            end
            RUN:  if (last) state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    a_r   <= a;
                    bx_r  <= sub ? ~b : b;
                    carry <= cin;
                    cnt   <= '0;
                end
                RUN: begin
                    s_r[idx +: DIGIT] <= s_d;
                    carry             <= c_d;
                    if (last) begin
                        // Overflow only depends on the sign bits, all known at the top digit.
                        cnt    <= '0;
                        cout_r <= c_d;
                        ovf_r  <= (a_r[WIDTH-1] == bx_r[WIDTH-1]) &&
                                  (s_d[DIGIT-1] != a_r[WIDTH-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
endmodule
